// File: rtl/chi_rx_chan_pkg.sv
// Shared CHI link-layer definitions: channel flit layouts,
// L-credit limits and credit-return opcodes.
package chi_rx_chan_pkg;

  localparam int CHI_MAX_LCRD = 15;

  localparam int REQ_OPC_W = 7;
  localparam int RSP_OPC_W = 5;
  localparam int SNP_OPC_W = 5;
  localparam int DAT_OPC_W = 4;

  localparam logic [REQ_OPC_W-1:0] REQ_LCRD_RET = 7'h00;
  localparam logic [RSP_OPC_W-1:0] RSP_LCRD_RET = 5'h00;
  localparam logic [SNP_OPC_W-1:0] SNP_LCRD_RET = 5'h00;
  localparam logic [DAT_OPC_W-1:0] DAT_LCRD_RET = 4'h0;

  // Opcode sits at the LSB of every layout so OPCODE_LSB stays 0.
  typedef struct packed {
    logic [3:0]           qos;
    logic [10:0]          tgt_id;
    logic [10:0]          src_id;
    logic [11:0]          txn_id;
    logic [51:0]          addr;
    logic [2:0]           size;
    logic [3:0]           order;
    logic [REQ_OPC_W-1:0] opcode;
  } reqflit_t;

  typedef struct packed {
    logic [3:0]           qos;
    logic [10:0]          tgt_id;
    logic [10:0]          src_id;
    logic [11:0]          txn_id;
    logic [11:0]          dbid;
    logic [2:0]           resp;
    logic [RSP_OPC_W-1:0] opcode;
  } rspflit_t;

  typedef struct packed {
    logic [3:0]           qos;
    logic [10:0]          src_id;
    logic [11:0]          txn_id;
    logic [48:0]          addr;
    logic [SNP_OPC_W-1:0] opcode;
  } snpflit_t;

  typedef struct packed {
    logic [255:0]         data;
    logic [31:0]          be;
    logic [10:0]          tgt_id;
    logic [10:0]          src_id;
    logic [11:0]          txn_id;
    logic [1:0]           data_id;
    logic [2:0]           resp;
    logic [DAT_OPC_W-1:0] opcode;
  } datflit_t;

endpackage

// File: rtl/chi_rx_chan_crd_ctr.sv
// L-credit counter: outstanding credits, issue decision,
// sticky protocol-error flag.
module chi_crd_ctr
  import chi_rx_chan_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int MAX_CRD = CHI_MAX_LCRD,
  parameter int CNT_W   = $clog2(DEPTH + 1),
  parameter int CRD_W   = $clog2(MAX_CRD + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             deact,
  input  logic             flitv,
  input  logic [CNT_W-1:0] count,
  output logic [CRD_W-1:0] crd_out,
  output logic             lcrdv,
  output logic             accept,
  output logic             err
);

  localparam int SUM_W = ((CNT_W > CRD_W) ? CNT_W : CRD_W) + 1;

  logic [SUM_W-1:0] sum;
  logic             issue;
  logic [CRD_W-1:0] crd_nxt;

  assign sum = SUM_W'(count) + SUM_W'(crd_out);

  assign issue = !deact
              && (sum < SUM_W'(DEPTH))
              && (crd_out < CRD_W'(MAX_CRD));

  // A flit with no credit behind it is dropped, not accepted.
  assign accept = flitv && (crd_out != '0);

  always_comb begin
    crd_nxt = crd_out;
    unique case (1'b1)
      issue && !accept: crd_nxt = crd_out + 1'b1;
      !issue && accept: crd_nxt = crd_out - 1'b1;
      default:          crd_nxt = crd_out;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      crd_out <= '0;
      lcrdv   <= 1'b0;
      err     <= 1'b0;
    end else begin
      crd_out <= crd_nxt;
      lcrdv   <= issue;
      if (flitv && (crd_out == '0))
        err <= 1'b1;
    end
  end

endmodule

// File: rtl/chi_rx_chan.sv
// CHI link-layer receive channel: credit issue, in-order
// flit queue, credit-return consumption and drain mode.
module chi_rx_chan
  import chi_rx_chan_pkg::*;
#(
  parameter int FLIT_W      = 128,
  parameter int DEPTH       = 8,
  parameter int MAX_CRD     = CHI_MAX_LCRD,
  parameter int OPCODE_LSB  = 0,
  parameter int OPCODE_W    = 7,
  parameter int CRD_RET_OPC = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [FLIT_W-1:0]          RXFLIT,
  input  logic                       RXFLITV,
  input  logic                       RXFLITPEND,
  output logic                       RXLCRDV,
  input  logic                       deact,
  output logic                       drained,
  output logic [FLIT_W-1:0]          out_flit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CRD_W = $clog2(MAX_CRD + 1);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic [CRD_W-1:0]  crd_out;
  logic              accept;
  logic              crd_ret;
  logic              enq;
  logic              deq;
  logic              unused_pend;

  assign unused_pend = RXFLITPEND;

  function automatic logic [PTR_W-1:0] ptr_inc(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  chi_crd_ctr #(
    .DEPTH   (DEPTH),
    .MAX_CRD (MAX_CRD),
    .CNT_W   (CNT_W),
    .CRD_W   (CRD_W)
  ) u_crd (
    .clock   (clock),
    .reset   (reset),
    .deact   (deact),
    .flitv   (RXFLITV),
    .count   (count),
    .crd_out (crd_out),
    .lcrdv   (RXLCRDV),
    .accept  (accept),
    .err     (err)
  );

  // Credit-return flits only give back their credit.
  assign crd_ret = RXFLIT[OPCODE_LSB +: OPCODE_W]
                == OPCODE_W'(CRD_RET_OPC);

  assign enq = accept && !crd_ret;
  assign deq = out_valid && out_ready;

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      enq && !deq: count_nxt = count + 1'b1;
      !enq && deq: count_nxt = count - 1'b1;
      default:     count_nxt = count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      count <= count_nxt;
      if (enq)
        wr_ptr <= ptr_inc(wr_ptr);
      if (deq)
        rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && enq)
      mem[wr_ptr] <= RXFLIT;
  end

  assign out_flit  = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign occupancy = count;
  assign drained   = deact && (crd_out == '0);

endmodule

// File: tb/tb_chi_rx_chan.sv
// Directed bench for chi_rx_chan: four instances at
// different depths, scoreboard-checked queue output.
module tb_chi_rx_chan;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic pend  = 1'b0;

  always #5 clk = ~clk;

  logic [15:0] flit0, flit1, flit2, flit3;
  logic        fv0, fv1, fv2, fv3;
  logic        dc0, dc1, dc2, dc3;
  logic        rd0, rd1, rd2, rd3;
  logic        lv0, lv1, lv2, lv3;
  logic        dr0, dr1, dr2, dr3;
  logic        ov0, ov1, ov2, ov3;
  logic        er0, er1, er2, er3;
  logic [15:0] of0, of1, of2, of3;
  logic [2:0]  oc0;
  logic [4:0]  oc1;
  logic [1:0]  oc2;
  logic [1:0]  oc3;

  chi_rx_chan #(.FLIT_W(16), .DEPTH(4)) u0 (
    .clock(clk), .reset(reset), .RXFLIT(flit0),
    .RXFLITV(fv0), .RXFLITPEND(pend), .RXLCRDV(lv0),
    .deact(dc0), .drained(dr0), .out_flit(of0),
    .out_valid(ov0), .out_ready(rd0),
    .occupancy(oc0), .err(er0));

  chi_rx_chan #(.FLIT_W(16), .DEPTH(16)) u1 (
    .clock(clk), .reset(reset), .RXFLIT(flit1),
    .RXFLITV(fv1), .RXFLITPEND(pend), .RXLCRDV(lv1),
    .deact(dc1), .drained(dr1), .out_flit(of1),
    .out_valid(ov1), .out_ready(rd1),
    .occupancy(oc1), .err(er1));

  chi_rx_chan #(.FLIT_W(16), .DEPTH(2)) u2 (
    .clock(clk), .reset(reset), .RXFLIT(flit2),
    .RXFLITV(fv2), .RXFLITPEND(pend), .RXLCRDV(lv2),
    .deact(dc2), .drained(dr2), .out_flit(of2),
    .out_valid(ov2), .out_ready(rd2),
    .occupancy(oc2), .err(er2));

  chi_rx_chan #(.FLIT_W(16), .DEPTH(3)) u3 (
    .clock(clk), .reset(reset), .RXFLIT(flit3),
    .RXFLITV(fv3), .RXFLITPEND(pend), .RXLCRDV(lv3),
    .deact(dc3), .drained(dr3), .out_flit(of3),
    .out_valid(ov3), .out_ready(rd3),
    .occupancy(oc3), .err(er3));

  int n_chk  = 0;
  int n_fail = 0;
  int pop0   = 0;
  int pop1   = 0;
  int pop3   = 0;
  int ncrd   = 0;
  int tb_crd = 0;
  int sent   = 0;

  logic [15:0] sbq0[$];
  logic [15:0] sbq1[$];
  logic [15:0] sbq3[$];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] fl(input int i);
    logic [7:0] hi;
    hi = 8'h40 + 8'(i);
    return {hi, 8'h15};
  endfunction

  // Pops are judged just before the edge that performs them.
  always @(negedge clk) begin
    if (reset === 1'b0 && ov0 === 1'b1 && rd0 === 1'b1) begin
      if (sbq0.size() == 0) check("pop0_unexp", 32'd1, 32'd0);
      else begin
        check("pop0", 32'(of0), 32'(sbq0.pop_front()));
        pop0++;
      end
    end
    if (reset === 1'b0 && ov1 === 1'b1 && rd1 === 1'b1) begin
      if (sbq1.size() == 0) check("pop1_unexp", 32'd1, 32'd0);
      else begin
        check("pop1", 32'(of1), 32'(sbq1.pop_front()));
        pop1++;
      end
    end
    if (reset === 1'b0 && ov3 === 1'b1 && rd3 === 1'b1) begin
      if (sbq3.size() == 0) check("pop3_unexp", 32'd1, 32'd0);
      else begin
        check("pop3", 32'(of3), 32'(sbq3.pop_front()));
        pop3++;
      end
    end
  end

  initial begin
    {flit0, flit1, flit2, flit3} = '0;
    {fv0, fv1, fv2, fv3} = '0;
    {dc0, dc1, dc2, dc3} = '0;
    {rd0, rd1, rd2, rd3} = '0;

    step();
    step();
    check("rst_lcrdv", 32'(lv0), 32'd0);
    check("rst_valid", 32'(ov0), 32'd0);
    check("rst_occ", 32'(oc0), 32'd0);
    check("rst_drained", 32'(dr0), 32'd0);
    check("rst_err", 32'(er0), 32'd0);
    reset = 1'b0;

    // idle credit issue: D4 then D16 capped at 15
    ncrd = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i <= 6) check("idle_crd4", 32'(lv0), 32'(i <= 4));
      ncrd += int'(lv1);
    end
    check("idle_occ4", 32'(oc0), 32'd0);
    check("crd16_total", 32'(ncrd), 32'd15);
    check("crd16_last", 32'(lv1), 32'd0);

    // fill D4 with out_ready low
    for (int i = 0; i < 4; i++) begin
      flit0 = fl(i);
      fv0 = 1'b1;
      sbq0.push_back(fl(i));
      step();
      check("fill_nocrd", 32'(lv0), 32'd0);
    end
    fv0 = 1'b0;
    check("fill_occ", 32'(oc0), 32'd4);
    step();
    check("full_nocrd", 32'(lv0), 32'd0);
    check("full_head", 32'(of0), 32'(fl(0)));
    check("full_valid", 32'(ov0), 32'd1);

    // drain: each pop frees a credit one cycle later
    rd0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("pop_crd", 32'(lv0), 32'(k >= 1));
    end
    rd0 = 1'b0;
    step();
    check("pop_crd_last", 32'(lv0), 32'd1);
    step();
    check("pop_crd_done", 32'(lv0), 32'd0);
    check("pop_count", 32'(pop0), 32'd4);
    check("pop_occ", 32'(oc0), 32'd0);

    // D16: one flit in and out regains exactly one credit
    flit1 = fl(9);
    fv1 = 1'b1;
    sbq1.push_back(fl(9));
    step();
    fv1 = 1'b0;
    rd1 = 1'b1;
    ncrd = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      ncrd += int'(lv1);
    end
    rd1 = 1'b0;
    check("crd16_refill", 32'(ncrd), 32'd1);
    check("pop16_count", 32'(pop1), 32'd1);

    // credit return under deact
    reset = 1'b1;
    sbq0.delete();
    step();
    reset = 1'b0;
    step();
    step();
    step();
    check("ret_third_crd", 32'(lv0), 32'd1);
    dc0 = 1'b1;
    check("ret_not_drained", 32'(dr0), 32'd0);
    step();
    check("deact_nocrd", 32'(lv0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      flit0 = 16'hAB00;
      fv0 = 1'b1;
      step();
      check("ret_nocrd", 32'(lv0), 32'd0);
      check("ret_occ", 32'(oc0), 32'd0);
      check("ret_drained", 32'(dr0), 32'(i == 2));
    end
    fv0 = 1'b0;
    step();
    check("drained_hold", 32'(dr0), 32'd1);
    check("drained_empty", 32'(ov0), 32'd0);
    dc0 = 1'b0;
    step();
    check("resume_crd", 32'(lv0), 32'd1);
    check("resume_undrained", 32'(dr0), 32'd0);

    // protocol error on D2
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    step();
    check("d2_nocrd", 32'(lv2), 32'd0);
    flit2 = fl(20);
    fv2 = 1'b1;
    step();
    flit2 = fl(21);
    step();
    fv2 = 1'b0;
    check("d2_full", 32'(oc2), 32'd2);
    check("d2_noerr", 32'(er2), 32'd0);
    flit2 = fl(22);
    fv2 = 1'b1;
    step();
    fv2 = 1'b0;
    check("err_set", 32'(er2), 32'd1);
    check("err_occ", 32'(oc2), 32'd2);
    step();
    step();
    step();
    check("err_sticky", 32'(er2), 32'd1);
    check("err_occ_hold", 32'(oc2), 32'd2);
    check("err_head", 32'(of2), 32'(fl(20)));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("err_cleared", 32'(er2), 32'd0);
    check("err_rst_occ", 32'(oc2), 32'd0);

    // D3 continuous traffic across pointer wrap
    reset = 1'b1;
    step();
    reset = 1'b0;
    sbq3.delete();
    pop3 = 0;
    tb_crd = 0;
    sent = 0;
    rd3 = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      tb_crd += int'(lv3);
      check("inv3", 32'((int'(oc3) + tb_crd) <= 3), 32'd1);
      if (sent < 10 && tb_crd > 0) begin
        flit3 = fl(30 + sent);
        fv3 = 1'b1;
        sbq3.push_back(fl(30 + sent));
        tb_crd--;
        sent++;
      end else begin
        fv3 = 1'b0;
      end
      if (sent == 10 && pop3 == 10) break;
    end
    fv3 = 1'b0;
    rd3 = 1'b0;
    check("wrap_pops", 32'(pop3), 32'd10);
    check("wrap_left", 32'(sbq3.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
